prime_gen_avalon_master: RTL and testbench

Avalon-MM initiator that drives the prime-generator responder.
- Programs the maximum value, waits for the responder's completion flag, then reads back a requested number of prime-table entries one at a time.
- Emits each entry on a valid/ready output stream.
- Sits between the system control logic and the prime responder; handles all bus handshakes, error responses and timeouts.

---
 rtl/prime_gen_avalon_master_if.sv | 36 +++
 rtl/prime_gen_avalon_master.sv | 176 +++++++++++++++++
 tb/tb_prime_gen_avalon_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prime_gen_avalon_master_if.sv
// Avalon-MM initiator bus plus output stream for the prime-table reader.
interface prime_gen_avalon_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [1:0]        avm_response;
  logic              avm_writeresponsevalid;
  logic              avm_done;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [8:0]        out_index;
  logic              out_ready;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  avm_response, avm_writeresponsevalid, avm_done,
    output out_valid, out_data, out_index,
    input  out_ready
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    output avm_response, avm_writeresponsevalid, avm_done,
    input  out_valid, out_data, out_index,
    output out_ready
  );
endinterface

// File: rtl/prime_gen_avalon_master.sv
// Programs the prime responder, then streams back table entries.
// Optional: PRIME_MASTER_STOP_ON_ZERO_EN ends the read-back at a zero entry.
module prime_gen_avalon_master #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_COUNT      = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_start,
  input  logic [9:0] cmd_max,
  input  logic [8:0] cmd_count,
  output logic       busy,
  output logic       cmd_done,
  output logic       err,
  output logic [1:0] err_code,
  prime_gen_avalon_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MAX,
    S_WR_RESP,
    S_WAIT_DONE,
    S_RD_REQ,
    S_RD_DATA,
    S_OUT,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t            state, state_nxt;
  logic [9:0]        max_q;
  logic [8:0]        count_q;
  logic [8:0]        index_q;
  logic [8:0]        index_inc;
  logic [8:0]        count_clip;
  logic [TW-1:0]     tmo_q;
  logic              tmo_en;
  logic              capture;
  logic [1:0]        code_nxt;
  logic [DATA_W-1:0] data_q;
  logic [8:0]        oidx_q;

  assign index_inc  = index_q + 9'd1;
  assign count_clip = (int'(cmd_count) > MAX_COUNT) ?
                      9'(MAX_COUNT) : cmd_count;

  assign bus.out_data  = data_q;
  assign bus.out_index = oidx_q;

  always_comb begin
    state_nxt         = state;
    code_nxt          = err_code;
    capture           = 1'b0;
    tmo_en            = 1'b0;
    busy              = 1'b0;
    cmd_done          = 1'b0;
    err               = 1'b0;
    bus.avm_address   = '0;
    bus.avm_write     = 1'b0;
    bus.avm_read      = 1'b0;
    bus.avm_writedata = '0;
    bus.out_valid     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_start) begin
          state_nxt = S_WR_MAX;
          code_nxt  = 2'b00;
        end
      end
      S_WR_MAX: begin
        busy              = 1'b1;
        tmo_en            = 1'b1;
        bus.avm_write     = 1'b1;
        bus.avm_writedata = DATA_W'(max_q);
        if (!bus.avm_waitrequest) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        busy   = 1'b1;
        tmo_en = 1'b1;
        if (bus.avm_writeresponsevalid) begin
          if (bus.avm_response == 2'b00) begin
            state_nxt = S_WAIT_DONE;
          end else begin
            state_nxt = S_FAIL;
            code_nxt  = 2'b01;
          end
        end
      end
      S_WAIT_DONE: begin
        busy   = 1'b1;
        tmo_en = 1'b1;
        if (bus.avm_done)
          state_nxt = (count_q != 9'd0) ? S_RD_REQ : S_FINISH;
      end
      S_RD_REQ: begin
        busy              = 1'b1;
        tmo_en            = 1'b1;
        bus.avm_read      = 1'b1;
        bus.avm_address   = ADDR_W'(1);
        bus.avm_writedata = DATA_W'(index_q);
        if (!bus.avm_waitrequest) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        busy   = 1'b1;
        tmo_en = 1'b1;
        if (bus.avm_readdatavalid) begin
`ifdef PRIME_MASTER_STOP_ON_ZERO_EN
          if (bus.avm_readdata == '0) begin
            state_nxt = S_FINISH;
          end else begin
            capture   = 1'b1;
            state_nxt = S_OUT;
          end
`else
          capture   = 1'b1;
          state_nxt = S_OUT;
`endif
        end
      end
      S_OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_nxt = (index_inc == count_q) ? S_FINISH : S_RD_REQ;
      end
      S_FINISH: begin
        cmd_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAIL: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A real event on the last allowed cycle still wins over the timeout.
    if (tmo_en && tmo_q == T_LAST && state_nxt == state) begin
      state_nxt = S_FAIL;
      code_nxt  = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      max_q    <= '0;
      count_q  <= '0;
      index_q  <= '0;
      tmo_q    <= '0;
      err_code <= '0;
      data_q   <= '0;
      oidx_q   <= '0;
    end else begin
      state    <= state_nxt;
      err_code <= code_nxt;
      tmo_q    <= (state_nxt != state) ? '0 : tmo_q + TW'(tmo_en);
      if (state == S_IDLE && cmd_start) begin
        max_q   <= cmd_max;
        count_q <= count_clip;
        index_q <= '0;
      end
      if (capture) begin
        data_q <= bus.avm_readdata;
        oidx_q <= index_q;
      end
      if (state == S_OUT && bus.out_ready) index_q <= index_inc;
    end
  end

endmodule

// File: tb/tb_prime_gen_avalon_master.sv
// Directed bench for prime_gen_avalon_master with a reactive responder model.
module tb_prime_gen_avalon_master;

  localparam int DW   = 32;
  localparam int AW   = 2;
  localparam int TMO  = 16;
  localparam int MAXC = 256;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       cmd_start = 1'b0;
  logic [9:0] cmd_max   = '0;
  logic [8:0] cmd_count = '0;
  logic       busy;
  logic       cmd_done;
  logic       err;
  logic [1:0] err_code;

  prime_gen_avalon_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  prime_gen_avalon_master #(
    .DATA_W(DW), .ADDR_W(AW),
    .TIMEOUT_CYCLES(TMO), .MAX_COUNT(MAXC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_max(cmd_max), .cmd_count(cmd_count),
    .busy(busy), .cmd_done(cmd_done), .err(err), .err_code(err_code),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] tbl [0:511];
  int          wr_stall_cfg = 0;
  int          rd_stall_cfg = 0;
  logic [31:0] rd_stall_idx = '1;
  int          hold_cfg     = 0;
  logic [8:0]  hold_idx     = '0;
  logic [1:0]  resp_cfg     = 2'b00;
  logic        done_cfg     = 1'b1;

  int          wr_stall_used = 0;
  int          rd_stall_used = 0;
  int          hold_used     = 0;
  logic        wrv_q   = 1'b0;
  logic        rdv_q   = 1'b0;
  logic [1:0]  resp_q  = 2'b00;
  logic [31:0] rdata_q = '0;
  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, rd_bad_addr = 0;
  int          wr_stall_seen = 0, rd_stall_seen = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  int          rd_idx_q[$];

  assign bus.avm_waitrequest =
    (bus.avm_write && wr_stall_used < wr_stall_cfg) ||
    (bus.avm_read && bus.avm_writedata == rd_stall_idx &&
     rd_stall_used < rd_stall_cfg);
  assign bus.avm_readdatavalid      = rdv_q;
  assign bus.avm_readdata           = rdata_q;
  assign bus.avm_response           = resp_q;
  assign bus.avm_writeresponsevalid = wrv_q;
  assign bus.avm_done               = done_cfg;
  assign bus.out_ready = !(bus.out_valid && bus.out_index == hold_idx &&
                           hold_used < hold_cfg);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    wrv_q <= 1'b0;
    rdv_q <= 1'b0;
    if (cmd_start) begin
      wr_stall_used <= 0;
      rd_stall_used <= 0;
      hold_used     <= 0;
    end else if (bus.out_valid && !bus.out_ready) begin
      hold_used <= hold_used + 1;
    end
    if (bus.avm_write) begin
      if (bus.avm_waitrequest) begin
        wr_stall_used <= wr_stall_used + 1;
        wr_stall_seen <= wr_stall_seen + 1;
      end else begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= 32'(bus.avm_address);
        wr_data <= bus.avm_writedata;
        wrv_q   <= 1'b1;
        resp_q  <= resp_cfg;
      end
    end
    if (bus.avm_read) begin
      if (bus.avm_waitrequest) begin
        rd_stall_used <= rd_stall_used + 1;
        rd_stall_seen <= rd_stall_seen + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
        rd_idx_q.push_back(int'(bus.avm_writedata));
        if (bus.avm_address != 2'd1) rd_bad_addr <= rd_bad_addr + 1;
        rdv_q   <= 1'b1;
        rdata_q <= tbl[bus.avm_writedata[8:0]];
      end
    end
  end

  int          done_cnt = 0, err_cnt = 0;
  int          t_resp = 0, t_err = 0;
  logic [31:0] got_data[$];
  int          got_idx[$];
  int          hold_cycles = 0, hold_bad = 0, stab_err = 0;
  logic        pw = 1'b0, pr = 1'b0, ps = 1'b0;
  logic [1:0]  pw_a = '0, pr_a = '0;
  logic [31:0] pw_d = '0, pr_d = '0, ps_d = '0;
  logic [8:0]  ps_i = '0;

  always @(negedge clk) begin
    if (cmd_done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      t_err   <= cyc;
    end
    if (bus.avm_writeresponsevalid) t_resp <= cyc;
    if (bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_idx.push_back(int'(bus.out_index));
    end
    if (bus.out_valid && !bus.out_ready) begin
      hold_cycles <= hold_cycles + 1;
      if (bus.out_data != 32'd5) hold_bad <= hold_bad + 1;
    end
    stab_err <= stab_err
      + ((pw && !(bus.avm_write && bus.avm_address == pw_a &&
                  bus.avm_writedata == pw_d)) ? 1 : 0)
      + ((pr && !(bus.avm_read && bus.avm_address == pr_a &&
                  bus.avm_writedata == pr_d)) ? 1 : 0)
      + ((ps && !(bus.out_valid && bus.out_data == ps_d &&
                  bus.out_index == ps_i)) ? 1 : 0);
    pw   <= bus.avm_write && bus.avm_waitrequest;
    pw_a <= bus.avm_address;
    pw_d <= bus.avm_writedata;
    pr   <= bus.avm_read && bus.avm_waitrequest;
    pr_a <= bus.avm_address;
    pr_d <= bus.avm_writedata;
    ps   <= bus.out_valid && !bus.out_ready;
    ps_d <= bus.out_data;
    ps_i <= bus.out_index;
  end

  int checks = 0;
  int errors = 0;
  int p10[10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
  int w0, r0, g0, d0, e0, h0, hb0, s0, ws0, rs0, base;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0   = wr_cnt;
    r0   = rd_cnt;
    g0   = got_data.size();
    d0   = done_cnt;
    e0   = err_cnt;
    h0   = hold_cycles;
    hb0  = hold_bad;
    s0   = stab_err;
    ws0  = wr_stall_seen;
    rs0  = rd_stall_seen;
    base = done_cnt + err_cnt;
  endtask

  task automatic start(input logic [9:0] m, input logic [8:0] c);
    @(posedge clk);
    #1;
    cmd_max   = m;
    cmd_count = c;
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int limit);
    int n;
    n = 0;
    while (done_cnt + err_cnt == base && n < limit) begin
      tick(1);
      n++;
    end
    chk({tag, " end"}, 32'(done_cnt + err_cnt - base), 32'd1);
    tick(2);
  endtask

  task automatic chk_primes(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data%0d", tag, i), got_data[g0 + i], 32'(p10[i]));
      chk($sformatf("%s idx%0d", tag, i), 32'(got_idx[g0 + i]), 32'(i));
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) tbl[i] = 32'(1000 + i);
    for (int i = 0; i < 10; i++) tbl[i] = 32'(p10[i]);

    tick(3);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst write", 32'(bus.avm_write), 32'd0);
    chk("rst read", 32'(bus.avm_read), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst done", 32'(cmd_done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst err_code", 32'(err_code), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // 1: basic run, plus a second start while busy that must be ignored
    snap();
    start(10'd30, 9'd10);
    chk("t1 busy", 32'(busy), 32'd1);
    tick(2);
    cmd_max   = 10'd7;
    cmd_count = 9'd3;
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
    wait_end("t1", 400);
    chk("t1 writes", 32'(wr_cnt - w0), 32'd1);
    chk("t1 wr_addr", wr_addr, 32'd0);
    chk("t1 wr_data", wr_data, 32'd30);
    chk("t1 reads", 32'(rd_cnt - r0), 32'd10);
    chk("t1 rd_addr", 32'(rd_bad_addr), 32'd0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t1 rd_idx%0d", i), 32'(rd_idx_q[r0 + i]), 32'(i));
    chk("t1 emitted", 32'(got_data.size() - g0), 32'd10);
    chk_primes("t1", 10);
    chk("t1 done", 32'(done_cnt - d0), 32'd1);
    chk("t1 no err", 32'(err_cnt - e0), 32'd0);
    chk("t1 busy low", 32'(busy), 32'd0);

    // 2: waitrequest stalls on the write and on read index 3
    wr_stall_cfg = 5;
    rd_stall_cfg = 5;
    rd_stall_idx = 32'd3;
    snap();
    start(10'd30, 9'd10);
    wait_end("t2", 400);
    chk("t2 wr stalls", 32'(wr_stall_seen - ws0), 32'd5);
    chk("t2 rd stalls", 32'(rd_stall_seen - rs0), 32'd5);
    chk("t2 stable", 32'(stab_err - s0), 32'd0);
    chk("t2 writes", 32'(wr_cnt - w0), 32'd1);
    chk("t2 reads", 32'(rd_cnt - r0), 32'd10);
    chk_primes("t2", 10);
    chk("t2 done", 32'(done_cnt - d0), 32'd1);
    wr_stall_cfg = 0;
    rd_stall_cfg = 0;

    // 3: write response error
    resp_cfg = 2'b01;
    snap();
    start(10'd30, 9'd10);
    wait_end("t3", 100);
    chk("t3 err", 32'(err_cnt - e0), 32'd1);
    chk("t3 no done", 32'(done_cnt - d0), 32'd0);
    chk("t3 err_code", 32'(err_code), 32'd1);
    chk("t3 reads", 32'(rd_cnt - r0), 32'd0);
    chk("t3 busy", 32'(busy), 32'd0);
    tick(5);
    chk("t3 code held", 32'(err_code), 32'd1);
    resp_cfg = 2'b00;

    // 4: responder never reports done
    done_cfg = 1'b0;
    snap();
    start(10'd30, 9'd4);
    wait_end("t4", 100);
    chk("t4 err", 32'(err_cnt - e0), 32'd1);
    chk("t4 err_code", 32'(err_code), 32'd2);
    chk("t4 latency", 32'(t_err - (t_resp + 1)), 32'd16);
    chk("t4 reads", 32'(rd_cnt - r0), 32'd0);
    done_cfg = 1'b1;

    // 5: consumer backpressure on index 2 for 100 cycles
    hold_cfg = 100;
    hold_idx = 9'd2;
    snap();
    start(10'd30, 9'd10);
    wait_end("t5", 600);
    chk("t5 hold cycles", 32'(hold_cycles - h0), 32'd100);
    chk("t5 hold data", 32'(hold_bad - hb0), 32'd0);
    chk("t5 stable", 32'(stab_err - s0), 32'd0);
    chk("t5 no err", 32'(err_cnt - e0), 32'd0);
    chk("t5 reads", 32'(rd_cnt - r0), 32'd10);
    chk_primes("t5", 10);
    hold_cfg = 0;

    // program only
    snap();
    start(10'd30, 9'd0);
    wait_end("t0cnt", 100);
    chk("t0cnt done", 32'(done_cnt - d0), 32'd1);
    chk("t0cnt writes", 32'(wr_cnt - w0), 32'd1);
    chk("t0cnt reads", 32'(rd_cnt - r0), 32'd0);
    chk("t0cnt emitted", 32'(got_data.size() - g0), 32'd0);

    // count above MAX_COUNT is clipped
    snap();
    start(10'd30, 9'd300);
    wait_end("tclip", 3000);
    chk("tclip reads", 32'(rd_cnt - r0), 32'd256);
    chk("tclip emitted", 32'(got_data.size() - g0), 32'd256);
    chk("tclip last idx", 32'(got_idx[g0 + 255]), 32'd255);
    chk("tclip last data", got_data[g0 + 255], 32'd1255);
    chk("tclip done", 32'(done_cnt - d0), 32'd1);

    // 6: table zero after index 3
    for (int i = 4; i < 8; i++) tbl[i] = 32'd0;
    snap();
    start(10'd10, 9'd8);
    wait_end("t6", 400);
    chk_primes("t6", 4);
    chk("t6 done", 32'(done_cnt - d0), 32'd1);
`ifdef PRIME_MASTER_STOP_ON_ZERO_EN
    chk("t6 emitted", 32'(got_data.size() - g0), 32'd4);
    chk("t6 reads", 32'(rd_cnt - r0), 32'd5);
`else
    chk("t6 emitted", 32'(got_data.size() - g0), 32'd8);
    chk("t6 reads", 32'(rd_cnt - r0), 32'd8);
    for (int i = 4; i < 8; i++) begin
      chk($sformatf("t6 zero%0d", i), got_data[g0 + i], 32'd0);
      chk($sformatf("t6 idx%0d", i), 32'(got_idx[g0 + i]), 32'(i));
    end
`endif

    // reset in the middle of a stalled read
    rd_stall_cfg = 10;
    rd_stall_idx = 32'd1;
    snap();
    start(10'd30, 9'd10);
    begin
      int n;
      n = 0;
      while (!(bus.avm_read && bus.avm_waitrequest) && n < 50) begin
        tick(1);
        n++;
      end
      chk("trst stalled read", 32'(bus.avm_read), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("trst busy", 32'(busy), 32'd0);
    chk("trst read", 32'(bus.avm_read), 32'd0);
    chk("trst write", 32'(bus.avm_write), 32'd0);
    chk("trst addr", 32'(bus.avm_address), 32'd0);
    chk("trst wdata", bus.avm_writedata, 32'd0);
    chk("trst out_valid", 32'(bus.out_valid), 32'd0);
    chk("trst out_data", bus.out_data, 32'd0);
    chk("trst out_index", 32'(bus.out_index), 32'd0);
    chk("trst done", 32'(cmd_done), 32'd0);
    chk("trst err", 32'(err), 32'd0);
    chk("trst err_code", 32'(err_code), 32'd0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
